// File: rtl/ras_ctrl.sv
// Return-address stack controller: CALL pushes, RET pops into ret_pc with a
// one-cycle redirect strobe; overflow/underflow park the FSM in ERROR until clear_err.
module ras_ctrl #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] call_pc,
    output logic [WIDTH-1:0] ret_pc,
    output logic             redirect_valid,
    output logic [PTR_W:0]   depth,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clear_err
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready depends only on state (1 in IDLE).
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        POP      = 2'd1,
        REDIRECT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [1:0]     OP_CALL   = 2'b01;
    localparam logic [1:0]     OP_RET    = 2'b10;
    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE       = (PTR_W + 1)'(1);

    state_t             state_q, state_d;
    logic [PTR_W:0]     depth_q, depth_d;
    logic [PTR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0]   ret_pc_q, ret_pc_d;
    logic               redirect_q, redirect_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic full_w, empty_w, accept;

    assign full_w  = (depth_q == DEPTH_MAX);
    assign empty_w = (depth_q == '0);
    assign accept  = req_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        rd_addr_d   = rd_addr_q;
        ret_pc_d    = ret_pc_q;
        redirect_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && req_op == OP_CALL) begin
                    if (full_w) begin
                        overflow_d = 1'b1;
                        state_d    = ERROR;
                    end else begin
                        mem_we  = 1'b1;
                        depth_d = depth_q + ONE;
                    end
                end else if (accept && req_op == OP_RET) begin
                    if (empty_w) begin
                        underflow_d = 1'b1;
                        state_d     = ERROR;
                    end else begin
                        depth_d   = depth_q - ONE;
                        rd_addr_d = depth_d[PTR_W-1:0];
                        state_d   = POP;
                    end
                end
            end
            POP: begin
                ret_pc_d   = mem_q[rd_addr_q];
                redirect_d = 1'b1;
                state_d    = REDIRECT;
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            ERROR: begin
                if (clear_err) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            depth_q     <= '0;
            rd_addr_q   <= '0;
            ret_pc_q    <= '0;
            redirect_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            rd_addr_q   <= rd_addr_d;
            ret_pc_q    <= ret_pc_d;
            redirect_q  <= redirect_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not cleared by reset; only the write is gated.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[depth_q[PTR_W-1:0]] <= call_pc;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign ret_pc         = ret_pc_q;
    assign redirect_valid = redirect_q;
    assign depth          = depth_q;
    assign full           = full_w;
    assign empty          = empty_w;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios then random CALL/RET/NOP traffic,
// checked against a queue-based stack model.
module tb_ras_ctrl;

    localparam int WIDTH = 18;
    localparam int DEPTH = 32;
    localparam int PTR_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [WIDTH-1:0] call_pc = '0;
    logic [WIDTH-1:0] ret_pc;
    logic             redirect_valid;
    logic [PTR_W:0]   depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic             clear_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] model_stk[$];
    logic [WIDTH-1:0] model_ret;
    logic             model_ovf;
    logic             model_unf;

    ras_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .call_pc        (call_pc),
        .ret_pc         (ret_pc),
        .redirect_valid (redirect_valid),
        .depth          (depth),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .underflow      (underflow),
        .clear_err      (clear_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_in_error();
        return model_ovf || model_unf;
    endfunction

    // Compare every architectural output with the model; ready/redirect
    // depend on where in a transaction we sample, so the caller supplies them.
    task automatic check_all(input string tag, input bit exp_ready, input bit exp_redirect);
        check_eq({tag, ".depth"},     32'(depth),     32'(model_stk.size()));
        check_eq({tag, ".full"},      32'(full),      32'(model_stk.size() == DEPTH));
        check_eq({tag, ".empty"},     32'(empty),     32'(model_stk.size() == 0));
        check_eq({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
        check_eq({tag, ".underflow"}, 32'(underflow), 32'(model_unf));
        check_eq({tag, ".ret_pc"},    32'(ret_pc),    32'(model_ret));
        check_eq({tag, ".ready"},     32'(req_ready), 32'(exp_ready));
        check_eq({tag, ".redirect"},  32'(redirect_valid), 32'(exp_redirect));
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_stk.delete();
        model_ret = '0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check_all("reset", 1'b1, 1'b0);
    endtask

    // Present one request for exactly one edge; inputs change #1 after the edge.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] pc);
        req_valid = 1'b1;
        req_op    = op;
        call_pc   = pc;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
    endtask

    task automatic do_call(input logic [WIDTH-1:0] pc);
        check_eq("call.pre_ready", 32'(req_ready), 32'(1));
        issue(2'b01, pc);
        if (model_stk.size() == DEPTH) begin
            model_ovf = 1'b1;
            check_all("call_ovf", 1'b0, 1'b0);
        end else begin
            model_stk.push_back(pc);
            check_all("call", 1'b1, 1'b0);
        end
    endtask

    task automatic do_ret();
        check_eq("ret.pre_ready", 32'(req_ready), 32'(1));
        issue(2'b10, '0);
        if (model_stk.size() == 0) begin
            model_unf = 1'b1;
            check_all("ret_unf", 1'b0, 1'b0);
            repeat (3) begin
                @(posedge clock);
                #1;
                check_all("ret_unf.hold", 1'b0, 1'b0);
            end
        end else begin
            logic [WIDTH-1:0] exp_pc;
            exp_pc = model_stk.pop_back();
            check_all("ret.edge_n", 1'b0, 1'b0);
            @(posedge clock);
            #1;
            model_ret = exp_pc;
            check_all("ret.edge_n1", 1'b0, 1'b1);
            @(posedge clock);
            #1;
            check_all("ret.edge_n2", 1'b1, 1'b0);
        end
    endtask

    task automatic do_nop(input logic [1:0] op);
        issue(op, 18'h2AAAA);
        check_all("nop", 1'b1, 1'b0);
    endtask

    task automatic do_clear();
        clear_err = 1'b1;
        @(posedge clock);
        #1;
        clear_err = 1'b0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check_all("clear", 1'b1, 1'b0);
    endtask

    // While in ERROR, hammer the request port and confirm nothing moves.
    task automatic poke_in_error(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            issue((i % 2 == 0) ? 2'b01 : 2'b10, WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            check_all("err.ignore", 1'b0, 1'b0);
        end
    endtask

    initial begin
        model_ret = '0;
        model_ovf = 1'b0;
        model_unf = 1'b0;

        apply_reset();

        do_call(18'h00010);
        do_call(18'h00020);
        do_call(18'h00030);
        do_ret();
        do_ret();
        do_ret();

        for (int i = 0; i < DEPTH; i++) do_call(WIDTH'(i));
        do_call(18'h3FFFF);
        poke_in_error(3);
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_ret();

        do_ret();
        poke_in_error(3);
        do_clear();

        // Reset landing on the POP cycle must swallow the pending redirect.
        do_call(18'h12345);
        do_call(18'h0ABCD);
        issue(2'b10, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst_pop.redirect", 32'(redirect_valid), 32'(0));
        check_eq("rst_pop.depth", 32'(depth), 32'(0));
        reset = 1'b0;
        model_stk.delete();
        model_ret = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
            check_all("rst_pop.after", 1'b1, 1'b0);
        end

        do_call(18'h00777);
        do_nop(2'b11);
        do_nop(2'b00);
        clear_err = 1'b1;
        @(posedge clock);
        #1;
        clear_err = 1'b0;
        check_all("clear_idle", 1'b1, 1'b0);
        do_ret();
        do_call(18'h00100);
        do_ret();

        for (int i = 0; i < 400; i++) begin
            int pick;
            if (model_in_error()) begin
                do_clear();
            end else begin
                pick = int'($urandom_range(0, 99));
                if (pick < 50)      do_call(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
                else if (pick < 88) do_ret();
                else                do_nop(2'($urandom_range(0, 1) * 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
